nes_frame_writer: RTL and testbench
===================================

# nes_frame_writer

Write-side pixel feeder for the NES video path, in the clk_write (CPU/PPU) domain. It accepts 6-bit palette colour codes from the PPU pixel pipeline with a valid/ready handshake and tracks raster position over a 256x240 frame. It buffers pixels in a small skid buffer and pushes them into the dual-clock video FIFO, respecting that FIFO's full flag. It also frames the stream with line/frame markers and counts aborted frames.

## Interface
- H_PIXELS, 256, pixels per line
- V_LINES, 240, lines per frame
- SKID_DEPTH, 4, skid buffer entries (power of two)
- clk_write  in  1  write-domain clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- frame_start  in  1  single-cycle pulse, start of a new PPU frame
- pix_valid  in  1  pix_code valid
- pix_code  in  6  NES palette index
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- fifo_full  in  1  video FIFO full, registered in clk_write domain
- fifo_write  out  1  push fifo_din into video FIFO this edge
- fifo_din  out  32  {26'b0, colour code}
- pix_x  out  8  x of next pixel to accept
- pix_y  out  8  y of next pixel to accept
- line_done  out  1  one-cycle pulse, line fully accepted
- frame_done  out  1  one-cycle pulse, frame fully written to FIFO
- busy  out  1  state != IDLE
- err_count  out  8  aborted frames, saturating

## Operation
- States: IDLE, ACTIVE, FLUSH.
- IDLE: pix_ready=0. On frame_start, zero pix_x/pix_y and go to ACTIVE.
- ACTIVE: pix_ready = (skid count < SKID_DEPTH) && !frame_start. This is combinational from registered state plus frame_start only; there is no path from fifo_full.
  - An accepted pixel is pushed into the skid buffer.
  - pix_x increments. When it wraps 255->0, pix_y increments.
  - After the pixel with x=H_PIXELS-1, y=V_LINES-1 is accepted, go to FLUSH.
- FLUSH: pix_ready=0. When the skid buffer is empty, go to IDLE and pulse frame_done.
- Drain runs in every state: fifo_write = skid nonempty && !fifo_full, with fifo_din = {26'b0, skid head}. The head pops on the same edge.
- A skid push and pop in the same cycle leaves the count unchanged.
- Order is preserved. No pixel is lost or duplicated except on abort or reset.
- Abort: frame_start while in ACTIVE or FLUSH has the following effects.
  - Skid buffer is discarded and fifo_write is forced to 0 that cycle.
  - Counters are zeroed.
  - err_count increments, saturating at 255.
  - State goes to ACTIVE.
  - frame_done and line_done do not pulse.
- pix_x is 8-bit and wraps naturally at 256. pix_y counts 0..V_LINES-1 and then holds at 0 after the frame completes.

## Timing
- Reset values: state IDLE, skid empty, and all outputs 0 (pix_ready, fifo_write, fifo_din, pix_x, pix_y, line_done, frame_done, busy, err_count).
- Reset mid-frame discards skid contents. fifo_write is 0 the cycle after reset.
- Latency: pixel accepted at edge N appears with fifo_write=1 in cycle N+1 if fifo_full=0. Sustained throughput is 1 pixel/cycle.
- line_done is registered. It is high in the cycle after acceptance of any pixel with x=H_PIXELS-1.
- frame_done is registered. It is high in the cycle after the edge that pops the last pixel, coincident with the IDLE state.
- With fifo_full held high, at most SKID_DEPTH further pixels are accepted before pix_ready drops.
- fifo_full rising is honoured the same cycle because fifo_write depends on it combinationally.
- frame_start in IDLE while pix_valid is high: that pixel is not accepted (pix_ready=0). The first acceptance can occur the next cycle.

## Test plan
- Full frame: reset, frame_start, then 61440 pixels with pix_code = index mod 64 and fifo_full=0.
  - Exactly 61440 fifo_write pulses, with fifo_din[5:0] matching order.
  - 240 line_done pulses.
  - One frame_done, one cycle after the last write; busy=0 afterwards.
- Backpressure: during line 3, hold fifo_full=1 for 20 cycles with pix_valid=1.
  - Exactly 4 pixels are accepted, then pix_ready=0.
  - No fifo_write while full.
  - After release the sequence is contiguous, with no gaps or duplicates.
- Abort: frame_start after 1000 accepted pixels with 2 in skid.
  - err_count=1, pix_x=0, pix_y=0, and no fifo_write that cycle.
  - The next accepted pixel is the first written.
  - frame_done does not fire for the aborted frame.
- IDLE guard: pix_valid=1 for 50 cycles without frame_start gives pix_ready=0, fifo_write=0, busy=0.
- Reset mid-frame: reset with 3 entries in skid.
  - Next cycle: fifo_write=0, pix_x=0, pix_y=0, err_count=0, IDLE.
  - A subsequent frame_start runs a clean frame.
- Saturation: 260 consecutive aborts leave err_count=255.

Source files
------------

// File: rtl/nes_frame_writer.sv
// Write-domain pixel feeder: accepts PPU palette codes, tracks raster position,
// buffers through a small skid FIFO and drains into the dual-clock video FIFO.
module nes_frame_writer #(
  parameter int H_PIXELS   = 256,
  parameter int V_LINES    = 240,
  parameter int SKID_DEPTH = 4
) (
  input  logic        clk_write,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [5:0]  pix_code,
  output logic        pix_ready,
  input  logic        fifo_full,
  output logic        fifo_write,
  output logic [31:0] fifo_din,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        line_done,
  output logic        frame_done,
  output logic        busy,
  output logic [7:0]  err_count,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [5:0]      skid_mem [SKID_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            abort, push, pop, line_end, last_pix;

  // Handshake: a pixel transfers on the rising edge where pix_valid && pix_ready;
  // pix_ready never looks at pix_valid or fifo_full, only at registered state and frame_start.
  always_comb begin
    abort      = frame_start && (state != S_IDLE);
    pix_ready  = !reset && (state == S_ACTIVE) && (count < CW'(SKID_DEPTH)) && !frame_start;
    push       = pix_valid && pix_ready;
    fifo_write = !reset && (count != '0) && !fifo_full && !abort;
    pop        = fifo_write;
    fifo_din   = fifo_write ? {26'b0, skid_mem[rd_ptr]} : 32'b0;
    line_end   = (pix_x == X_LAST);
    last_pix   = push && line_end && (pix_y == Y_LAST);
    count_next = count + CW'(push) - CW'(pop);
    busy       = (state != S_IDLE);
    dbg_state  = state;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (frame_start) state_next = S_ACTIVE;
      S_ACTIVE: begin
        if (abort)         state_next = S_ACTIVE;
        else if (last_pix) state_next = S_FLUSH;
      end
      // Leave on the edge that pops the final entry so frame_done lines up with IDLE.
      S_FLUSH: begin
        if (abort)                  state_next = S_ACTIVE;
        else if (count_next == '0)  state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_write) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_write) begin
    if (push) skid_mem[wr_ptr] <= pix_code;
  end

  always_ff @(posedge clk_write) begin
    if (reset || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk_write) begin
    if (reset || frame_start) begin
      pix_x <= '0;
      pix_y <= '0;
    end else if (push) begin
      pix_x <= pix_x + 8'd1;
      if (line_end) pix_y <= (pix_y == Y_LAST) ? 8'd0 : pix_y + 8'd1;
    end
  end

  always_ff @(posedge clk_write) begin
    if (reset) begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      line_done  <= push && line_end;
      frame_done <= (state == S_FLUSH) && (state_next == S_IDLE);
      if (abort && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_nes_frame_writer.sv
// Bench for nes_frame_writer: random/structured stimulus, an expected-pixel queue
// and a frame-level reference model checked every cycle on the falling edge.
module tb_nes_frame_writer;

  localparam int FRAME_PIX = 256 * 240;

  logic        clk_write;
  logic        reset;
  logic        frame_start;
  logic        pix_valid;
  logic [5:0]  pix_code;
  logic        pix_ready;
  logic        fifo_full;
  logic        fifo_write;
  logic [31:0] fifo_din;
  logic [7:0]  pix_x, pix_y;
  logic        line_done, frame_done, busy;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  nes_frame_writer dut (
    .clk_write   (clk_write),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_code    (pix_code),
    .pix_ready   (pix_ready),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_din    (fifo_din),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .line_done   (line_done),
    .frame_done  (frame_done),
    .busy        (busy),
    .err_count   (err_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk_write = 1'b0;
  always #5 clk_write = ~clk_write;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // pusher: records every accepted pixel as an expected FIFO word
  int acc_drv = 0;
  always @(negedge clk_write) begin
    #1;
    if (!reset && pix_valid && pix_ready) begin
      exp_q.push_back(pix_code);
      acc_drv++;
    end
  end

  // reference model + monitor: mode 0 idle, 1 accepting, 2 draining
  int          mode = 0;
  int          macc = 0;
  int          err_m = 0;
  bit          exp_line = 0, exp_frame = 0;
  bit          m_abort, m_ready, m_write, was_flush;
  logic [5:0]  m_pix;
  int          n_writes = 0, n_line = 0, n_frame = 0;

  always @(negedge clk_write) begin
    if (reset) begin
      exp_q.delete();
      mode = 0; macc = 0; err_m = 0; exp_line = 0; exp_frame = 0;
    end else begin
      was_flush = (mode == 2);
      m_abort   = frame_start && (mode != 0);
      m_ready   = (mode == 1) && (exp_q.size() < 4) && !frame_start;
      m_write   = (exp_q.size() > 0) && !fifo_full && !m_abort;
      chk("pix_ready", pix_ready, m_ready);
      chk("fifo_write", fifo_write, m_write);
      if (fifo_write) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          chk("fifo_write_underflow", 1, 0);
        end else begin
          m_pix = exp_q.pop_front();
          chk("fifo_din", fifo_din, {26'b0, m_pix});
        end
      end
      chk("pix_x", pix_x, macc % 256);
      chk("pix_y", pix_y, (macc == FRAME_PIX) ? 0 : macc / 256);
      chk("busy", busy, mode != 0);
      chk("err_count", err_count, err_m);
      chk("line_done", line_done, exp_line);
      chk("frame_done", frame_done, exp_frame);
      if (line_done)  n_line++;
      if (frame_done) n_frame++;
      exp_line = 0;
      exp_frame = 0;
      if (m_abort) begin
        exp_q.delete();
        err_m = (err_m < 255) ? err_m + 1 : 255;
        mode = 1; macc = 0;
      end else if (frame_start) begin
        mode = 1; macc = 0;
      end else begin
        if (pix_valid && m_ready) begin
          exp_line = (macc % 256 == 255);
          macc++;
          if (macc == FRAME_PIX) mode = 2;
        end
        if (was_flush && exp_q.size() == 0) begin
          mode = 0;
          exp_frame = 1;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_write);
    #1;
  endtask

  task automatic rand_cycles(input int n, input int full_pct);
    for (int i = 0; i < n; i++) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      fifo_full = ($urandom_range(0, 99) < full_pct);
      pix_code  = 6'($urandom_range(0, 63));
      tick();
    end
  endtask

  task automatic backpressure();
    int start, w0;
    pix_valid = 1'b0;
    tick();
    fifo_full = 1'b1;
    pix_valid = 1'b1;
    start = acc_drv;
    w0 = n_writes;
    repeat (20) begin
      pix_code = 6'(acc_drv);
      tick();
    end
    chk("bp_accepted", acc_drv - start, 4);
    chk("bp_no_write", n_writes - w0, 0);
    chk("bp_ready_low", pix_ready, 0);
    fifo_full = 1'b0;
  endtask

  initial begin
    int c, f0, w0;
    bit bp_done;
    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_code = '0; fifo_full = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk_write);
    chk("reset_fifo_din", fifo_din, 0);
    chk("reset_pix_ready", pix_ready, 0);
    tick();

    // full frame, index-mod-64 codes, backpressure during line 3
    n_writes = 0; n_line = 0; n_frame = 0;
    pix_valid = 1'b1;
    frame_start = 1'b1;
    acc_drv = 0;
    tick();
    frame_start = 1'b0;
    bp_done = 0;
    c = 0;
    while (acc_drv < FRAME_PIX && c < 70000) begin
      if (!bp_done && acc_drv == 3 * 256 + 16) begin
        backpressure();
        bp_done = 1;
      end
      pix_code = 6'(acc_drv);
      tick();
      c++;
    end
    if (acc_drv < FRAME_PIX) chk("frame_accept_timeout", acc_drv, FRAME_PIX);
    pix_valid = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      tick();
      c++;
    end
    chk("flush_timeout", busy, 0);
    repeat (2) tick();
    chk("frame_writes", n_writes, FRAME_PIX);
    chk("frame_lines", n_line, 240);
    chk("frame_dones", n_frame, 1);

    // idle guard
    pix_valid = 1'b1;
    w0 = n_writes;
    repeat (50) tick();
    chk("idle_writes", n_writes - w0, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", pix_ready, 0);
    pix_valid = 1'b0;

    // abort after 1000 accepted pixels with two in the skid buffer
    f0 = n_frame;
    acc_drv = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_valid = 1'b1;
    c = 0;
    while (acc_drv < 998 && c < 3000) begin
      pix_code = 6'($urandom_range(0, 63));
      tick();
      c++;
    end
    pix_valid = 1'b0;
    tick();
    fifo_full = 1'b1;
    pix_valid = 1'b1;
    repeat (2) begin
      pix_code = 6'($urandom_range(0, 63));
      tick();
    end
    chk("abort_setup_count", acc_drv, 1000);
    pix_valid = 1'b0;
    fifo_full = 1'b0;
    frame_start = 1'b1;
    @(negedge clk_write);
    chk("abort_no_write", fifo_write, 0);
    tick();
    frame_start = 1'b0;
    chk("abort_err", err_count, 1);
    chk("abort_x", pix_x, 0);
    chk("abort_y", pix_y, 0);
    rand_cycles(300, 25);
    chk("abort_no_frame_done", n_frame - f0, 0);

    // reset with three entries held in the skid buffer
    pix_valid = 1'b0; fifo_full = 1'b0;
    repeat (6) tick();
    fifo_full = 1'b1;
    pix_valid = 1'b1;
    repeat (3) begin
      pix_code = 6'($urandom_range(0, 63));
      tick();
    end
    pix_valid = 1'b0;
    fifo_full = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_fifo_write", fifo_write, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_err", err_count, 0);
    chk("rst_busy", busy, 0);
    tick();

    // clean partial frame after reset
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rand_cycles(2000, 20);

    // back-to-back aborts saturate the error counter
    pix_valid = 1'b1;
    fifo_full = 1'b0;
    frame_start = 1'b1;
    repeat (270) tick();
    frame_start = 1'b0;
    pix_valid = 1'b0;
    tick();
    chk("err_saturated", err_count, 255);
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
